// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one single-cycle ALU between two requesters. A round-robin grant
//   picks one request, its operands are registered and drive the ALU for one
//   cycle, and the ALU result and Zero flag are captured and returned with the
//   requester ID. Only one operation is in flight at a time
//   (IDLE -> EXEC -> RESP -> IDLE).
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   req0_* / req1_*              valid/ready request channels with a, b, ctrl
//   alu_srca/alu_srcb/alu_ctrl   registered operands to the shared ALU
//   alu_result/alu_zero          combinational ALU outputs
//   resp_valid/resp_ready        response handshake
//   resp_id/resp_result/resp_zero  response payload
//   ops_done                     completed responses, wraps
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [DATA_WIDTH-1:0]  req0_a,
   input  logic [DATA_WIDTH-1:0]  req0_b,
   input  logic [2:0]             req0_ctrl,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [DATA_WIDTH-1:0]  req1_a,
   input  logic [DATA_WIDTH-1:0]  req1_b,
   input  logic [2:0]             req1_ctrl,
   output logic [DATA_WIDTH-1:0]  alu_srca,
   output logic [DATA_WIDTH-1:0]  alu_srcb,
   output logic [2:0]             alu_ctrl,
   input  logic [DATA_WIDTH-1:0]  alu_result,
   input  logic                   alu_zero,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic                   resp_id,
   output logic [DATA_WIDTH-1:0]  resp_result,
   output logic                   resp_zero,
   output logic [COUNT_WIDTH-1:0] ops_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state_reg;
   logic                    last_grant_reg;
   logic                    id_reg;
   logic [DATA_WIDTH-1:0]   op_a_reg;
   logic [DATA_WIDTH-1:0]   op_b_reg;
   logic [2:0]              op_ctrl_reg;
   logic [DATA_WIDTH-1:0]   result_reg;
   logic                    zero_reg;
   logic                    resp_valid_reg;
   logic [COUNT_WIDTH-1:0]  ops_done_reg;

   logic                    grant_any;
   logic                    grant_id;
   logic                    accept;

   // Round-robin: a lone requester wins outright; on contention the one
   // that was not granted last time wins.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      grant_id  = 1'b0;
      if (req0_valid && req1_valid)
         grant_id = ~last_grant_reg;
      else if (req1_valid)
         grant_id = 1'b1;
   end

   // Readies are gated by rst_n so every output reads 0 while reset is held.
   assign req0_ready = rst_n & (state_reg == IDLE) & grant_any & ~grant_id;
   assign req1_ready = rst_n & (state_reg == IDLE) & grant_any &  grant_id;
   assign accept     = req0_ready | req1_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         id_reg         <= 1'b0;
         op_a_reg       <= '0;
         op_b_reg       <= '0;
         op_ctrl_reg    <= '0;
         result_reg     <= '0;
         zero_reg       <= 1'b0;
         resp_valid_reg <= 1'b0;
         ops_done_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op_a_reg       <= grant_id ? req1_a    : req0_a;
                  op_b_reg       <= grant_id ? req1_b    : req0_b;
                  op_ctrl_reg    <= grant_id ? req1_ctrl : req0_ctrl;
                  id_reg         <= grant_id;
                  last_grant_reg <= grant_id;
                  state_reg      <= EXEC;
               end
            end
            EXEC: begin
               // Operand registers have driven the ALU for this whole cycle.
               result_reg     <= alu_result;
               zero_reg       <= alu_zero;
               resp_valid_reg <= 1'b1;
               state_reg      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_reg <= 1'b0;
                  ops_done_reg   <= ops_done_reg + 1'b1;
                  state_reg      <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign alu_srca    = op_a_reg;
   assign alu_srcb    = op_b_reg;
   assign alu_ctrl    = op_ctrl_reg;
   assign resp_valid  = resp_valid_reg;
   assign resp_id     = id_reg;
   assign resp_result = result_reg;
   assign resp_zero   = zero_reg;
   assign ops_done    = ops_done_reg;

endmodule
